wb_regfile: RTL and testbench

Writeback stage and architectural state for the 16-bit core: accepts ALU results and next-flag values, buffers them in a 2-entry queue, and commits them to an 8×16 register file and the 4-bit flag register. It sits directly downstream of the ALU and also serves the operand read ports that feed the ALU's `src1`/`src2`, closing the execute loop.

---
 rtl/wb_regfile.sv | 111 +++++++++++
 tb/tb_wb_regfile.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Writeback stage: 2-entry result queue committing into an NREGS x DW register file and flag register.
// Optional macro WB_FORWARD_EN: forward pending writes to the read ports instead of raising hazard.
module wb_regfile #(
  parameter  int NREGS = 8,
  parameter  int DW    = 16,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_rd,
  input  logic          in_we,
  input  logic [DW-1:0] in_data,
  input  logic          in_fe,
  input  logic [3:0]    in_flags,
  input  logic          wb_hold,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  output logic [DW-1:0] rs1_data,
  output logic [DW-1:0] rs2_data,
  output logic [3:0]    flags,
  output logic          hazard
);

  typedef struct packed {
    logic [AW-1:0] rd;
    logic          we;
    logic [DW-1:0] data;
    logic          fe;
    logic [3:0]    flags;
  } entry_t;

  entry_t        q_mem [2];
  entry_t        in_ent;
  logic          head_q, tail_q;
  logic [1:0]    count_q, count_d;
  logic [DW-1:0] regs_q [NREGS];
  logic [3:0]    flags_q;
  logic          push, pop;

  // in_ready comes from the registered count, so a pop from a full queue never admits a same-edge push.
  assign in_ready = (count_q != 2'd2);
  assign push     = in_valid && in_ready;
  assign pop      = (count_q != 2'd0) && !wb_hold;
  assign count_d  = count_q + 2'(push) - 2'(pop);
  assign in_ent   = '{rd: in_rd, we: in_we, data: in_data, fe: in_fe, flags: in_flags};

  // NOTE: queue payload is left unreset; count_q alone decides which slots are meaningful.
  always_ff @(posedge clk) begin
    if (push) q_mem[tail_q] <= in_ent;
  end

  // NOTE: non-blocking assignments keep the head read below the pre-edge value even when a push hits the same slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      flags_q <= '0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= ~tail_q;
      if (pop) begin
        head_q <= ~head_q;
        if (q_mem[head_q].we) regs_q[q_mem[head_q].rd] <= q_mem[head_q].data;
        if (q_mem[head_q].fe) flags_q <= q_mem[head_q].flags;
      end
      count_q <= count_d;
    end
  end

  // Read ports scan oldest (k=0, head) then youngest (k=1) so the youngest match wins.
  logic [AW-1:0] rs_addr [2];
  logic [DW-1:0] rs_data [2];
  logic [1:0]    rs_hit;
  logic [1:0]    pend_vld;
  logic          slot;

  assign rs_addr[0] = rs1_addr;
  assign rs_addr[1] = rs2_addr;
  assign pend_vld   = {count_q == 2'd2, count_q != 2'd0};

  always_comb begin
    slot = 1'b0;
    for (int p = 0; p < 2; p++) begin
      rs_data[p] = regs_q[rs_addr[p]];
      rs_hit[p]  = 1'b0;
      for (int k = 0; k < 2; k++) begin
        slot = head_q ^ k[0];
        if (pend_vld[k] && q_mem[slot].we && (q_mem[slot].rd == rs_addr[p])) begin
          rs_hit[p] = 1'b1;
`ifdef WB_FORWARD_EN
          rs_data[p] = q_mem[slot].data;
`endif
        end
      end
    end
  end

  assign rs1_data = rs_data[0];
  assign rs2_data = rs_data[1];
  assign flags    = flags_q;

`ifdef WB_FORWARD_EN
  assign hazard = 1'b0;
`else
  assign hazard = |rs_hit;
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: pushed entries queue up in the model and are applied at each commit edge.
module tb_wb_regfile;

  typedef struct packed {
    logic [2:0]  rd;
    logic        we;
    logic [15:0] data;
    logic        fe;
    logic [3:0]  flags;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_rd = '0;
  logic        in_we = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_fe = 1'b0;
  logic [3:0]  in_flags = '0;
  logic        wb_hold = 1'b0;
  logic [2:0]  rs1_addr = '0;
  logic [2:0]  rs2_addr = '0;
  logic [15:0] rs1_data, rs2_data;
  logic [3:0]  flags;
  logic        hazard;

  int errors = 0;
  int checks = 0;

  ent_t        mq[$];
  logic [15:0] m_regs [8];
  logic [3:0]  m_flags;

  wb_regfile #(.NREGS(8), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_we(in_we), .in_data(in_data), .in_fe(in_fe), .in_flags(in_flags),
    .wb_hold(wb_hold),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .flags(flags), .hazard(hazard)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] exp_read(input logic [2:0] a);
    logic [15:0] v;
    v = m_regs[a];
`ifdef WB_FORWARD_EN
    foreach (mq[i]) if (mq[i].we && mq[i].rd == a) v = mq[i].data;
`endif
    return v;
  endfunction

  function automatic logic exp_hazard(input logic [2:0] a1, input logic [2:0] a2);
    logic h;
    h = 1'b0;
`ifndef WB_FORWARD_EN
    foreach (mq[i]) if (mq[i].we && (mq[i].rd == a1 || mq[i].rd == a2)) h = 1'b1;
`endif
    return h;
  endfunction

  function automatic ent_t mk(input logic [2:0] rd, input logic we, input logic [15:0] d,
                              input logic fe, input logic [3:0] f);
    mk = '{rd: rd, we: we, data: d, fe: fe, flags: f};
  endfunction

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_flags = '0;
  endtask

  // One clock of stimulus; the model pops its head on a commit edge and readback is compared.
  task automatic drive_cycle(input logic v, input ent_t e, input logic hold);
    logic acc, com, exp_rdy;
    ent_t c;
    @(negedge clk);
    in_valid = v; in_rd = e.rd; in_we = e.we; in_data = e.data;
    in_fe = e.fe; in_flags = e.flags; wb_hold = hold;
    #1;
    exp_rdy = (mq.size() < 2);
    checks++;
    if (in_ready !== exp_rdy) begin
      errors++;
      $display("FAIL in_ready: got %b expected %b", in_ready, exp_rdy);
    end
    acc = v && exp_rdy;
    com = (mq.size() > 0) && !hold;
    c = '0;
    @(posedge clk);
    if (com) begin
      c = mq.pop_front();
      if (c.we) m_regs[c.rd] = c.data;
      if (c.fe) m_flags = c.flags;
    end
    if (acc) mq.push_back(e);
    #1;
    in_valid = 1'b0;
    checks++;
    if (flags !== m_flags) begin
      errors++;
      $display("FAIL flags: got %b expected %b", flags, m_flags);
    end
    if (com && c.we) begin
      rs1_addr = c.rd;
      #1;
      checks++;
      if (rs1_data !== exp_read(c.rd)) begin
        errors++;
        $display("FAIL commit_read r%0d: got %h expected %h", c.rd, rs1_data, exp_read(c.rd));
      end
    end
  endtask

  task automatic probe_reads(input logic [2:0] a1, input logic [2:0] a2);
    rs1_addr = a1;
    rs2_addr = a2;
    #1;
    checks++;
    if (rs1_data !== exp_read(a1) || rs2_data !== exp_read(a2) || hazard !== exp_hazard(a1, a2)) begin
      errors++;
      $display("FAIL reads r%0d/r%0d: got %h %h hz=%b expected %h %h hz=%b", a1, a2,
               rs1_data, rs2_data, hazard, exp_read(a1), exp_read(a2), exp_hazard(a1, a2));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, 1'b0);
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    for (int i = 0; i < 8; i++) begin
      rs1_addr = 3'(i);
      rs2_addr = 3'(7 - i);
      #1;
      checks++;
      if (rs1_data !== 16'h0000 || rs2_data !== 16'h0000) begin
        errors++;
        $display("FAIL reset_regs r%0d: got %h %h expected 0000", i, rs1_data, rs2_data);
      end
    end
    checks++;
    if (flags !== 4'b0000 || in_ready !== 1'b1 || hazard !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: flags=%b rdy=%b hz=%b expected 0000 1 0", flags, in_ready, hazard);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_commit();
    drive_cycle(1'b1, mk(3'd3, 1'b1, 16'h1234, 1'b1, 4'b0100), 1'b0);
    probe_reads(3'd3, 3'd0);
    drive_cycle(1'b0, '0, 1'b0);
    rs1_addr = 3'd3;
    #1;
    checks++;
    if (rs1_data !== 16'h1234 || flags !== 4'b0100) begin
      errors++;
      $display("FAIL single_commit: got r3=%h flags=%b expected 1234 0100", rs1_data, flags);
    end
  endtask

  task automatic test_hold_full();
    drive_cycle(1'b1, mk(3'd1, 1'b1, 16'hAAAA, 1'b0, 4'b0000), 1'b1);
    drive_cycle(1'b1, mk(3'd1, 1'b1, 16'hBBBB, 1'b0, 4'b0000), 1'b1);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: got %b expected 0", in_ready);
    end
    probe_reads(3'd3, 3'd1);
    // Full with hold still set: offered entry must be refused.
    drive_cycle(1'b1, mk(3'd2, 1'b1, 16'hCCCC, 1'b0, 4'b0000), 1'b1);
    // Releasing hold while full: head commits, the offered entry is still refused.
    drive_cycle(1'b1, mk(3'd2, 1'b1, 16'hDDDD, 1'b0, 4'b0000), 1'b0);
    drive_cycle(1'b0, '0, 1'b0);
    rs1_addr = 3'd1;
    rs2_addr = 3'd2;
    #1;
    checks++;
    if (rs1_data !== 16'hBBBB || rs2_data !== 16'h0000 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_drain: got r1=%h r2=%h rdy=%b expected BBBB 0000 1", rs1_data, rs2_data, in_ready);
    end
  endtask

  task automatic test_flags_only();
    drive_cycle(1'b1, mk(3'd5, 1'b0, 16'hDEAD, 1'b1, 4'b1001), 1'b0);
    drive_cycle(1'b1, mk(3'd6, 1'b0, 16'hBEEF, 1'b0, 4'b1111), 1'b0);
    drive_cycle(1'b0, '0, 1'b0);
    rs1_addr = 3'd5;
    rs2_addr = 3'd6;
    #1;
    checks++;
    if (rs1_data !== 16'h0000 || rs2_data !== 16'h0000 || flags !== 4'b1001 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flags_only: got r5=%h r6=%h flags=%b rdy=%b expected 0000 0000 1001 1",
               rs1_data, rs2_data, flags, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b1, mk(3'(i), 1'b1, 16'($urandom), 1'($urandom), 4'($urandom)), 1'b0);
      probe_reads(3'(i), 3'(i + 1));
    end
    idle(2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      drive_cycle(1'($urandom_range(0, 3) != 0), mk(3'($urandom), 1'($urandom), 16'($urandom),
                  1'($urandom), 4'($urandom)), 1'($urandom_range(0, 2) == 0));
      probe_reads(3'($urandom), 3'($urandom));
    end
    idle(3);
  endtask

  task automatic test_reset_mid();
    drive_cycle(1'b1, mk(3'd4, 1'b1, 16'h4444, 1'b1, 4'b0110), 1'b1);
    drive_cycle(1'b1, mk(3'd6, 1'b1, 16'h6666, 1'b0, 4'b0000), 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    rs1_addr = 3'd4;
    rs2_addr = 3'd1;
    #1;
    checks++;
    if (rs1_data !== 16'h0000 || rs2_data !== 16'h0000 || in_ready !== 1'b1 ||
        hazard !== 1'b0 || flags !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid: got r4=%h r1=%h rdy=%b hz=%b flags=%b expected 0000 0000 1 0 0000",
               rs1_data, rs2_data, in_ready, hazard, flags);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    rs1_addr = 3'd4;
    rs2_addr = 3'd6;
    #1;
    checks++;
    if (rs1_data !== 16'h0000 || rs2_data !== 16'h0000 || flags !== 4'b0000) begin
      errors++;
      $display("FAIL reset_discard: got r4=%h r6=%h flags=%b expected 0000 0000 0000",
               rs1_data, rs2_data, flags);
    end
  endtask

  initial begin
    test_reset();
    test_single_commit();
    test_hold_full();
    test_flags_only();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
